// File: rtl/nunchuck_pkg.sv
// Shared definitions for the nunchuck I2C responder: FSM states, bus address,
// init-sequence register/value pairs, and the report-buffer size plus a helper
// that packs the accelerometer LSBs and button bits into the last report byte.
package nunchuck_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } state_t;

    localparam logic [6:0] NUNCHUCK_ADDR  = 7'h52;
    localparam logic [7:0] INIT_REG1      = 8'hF0;
    localparam logic [7:0] INIT_VAL1      = 8'h55;
    localparam logic [7:0] INIT_REG2      = 8'hFB;
    localparam logic [7:0] INIT_VAL2      = 8'h00;
    localparam int         NUM_DATA_BYTES = 6;

    // Byte 5 of the report: accel LSB pairs, then active-low buttons.
    function automatic logic [7:0] low_bits_byte(input logic [9:0] ax,
                                                 input logic [9:0] ay,
                                                 input logic [9:0] az,
                                                 input logic       btn_c,
                                                 input logic       btn_z);
        return {az[1:0], ay[1:0], ax[1:0], ~btn_c, ~btn_z};
    endfunction

endpackage

// File: rtl/nunchuck_responder_i2c_bus_sync.sv
// I2C bus front end: 2-flop synchronizers on scl/sda, a third registered copy
// for edge detection, and single-clk pulses for scl rise/fall, START and STOP.
// Ports: clk, rst (sync, active-high), raw scl/sda in; sda_s, scl_rise, scl_fall, start, stop out.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_ff;
    logic [1:0] sda_ff;
    logic       scl_d;
    logic       sda_d;
    logic       scl_s;

    // Reset to the idle-bus level so leaving reset never fakes a START.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[0], scl};
            sda_ff <= {sda_ff[0], sda};
            scl_d  <= scl_ff[1];
            sda_d  <= sda_ff[1];
        end
    end

    assign scl_s    = scl_ff[1];
    assign sda_s    = sda_ff[1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start    = scl_s & scl_d & sda_d & ~sda_s;
    assign stop     = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/nunchuck_responder.sv
// I2C target emulating a Wii nunchuck: register-pointer writes, init detection,
// and coherent 6-byte report reads snapshotted at read-address ACK.
// Ports: clk, rst, scl, sda (open-drain), stick/accel/button inputs; init_done, busy, reg_ptr out.
module nunchuck_responder
    import nunchuck_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = NUNCHUCK_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] stick_x,
    input  logic [7:0] stick_y,
    input  logic [9:0] accel_x,
    input  logic [9:0] accel_y,
    input  logic [9:0] accel_z,
    input  logic       z,
    input  logic       c,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] reg_ptr
);

    logic       sda_s, scl_rise, scl_fall, start, stop;
    state_t     state;
    logic       sda_oe;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic       first_wr;
    logic       init_armed;
    logic       mst_ack;
    logic [7:0] snap [NUM_DATA_BYTES];
    logic [7:0] rd_data;

    i2c_bus_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign sda = sda_oe ? 1'b0 : 1'bz;

    // Byte presented for the current pointer; all-ones until init completes.
    always_comb begin
        rd_data = 8'hFF;
        if (init_done && reg_ptr < 8'(NUM_DATA_BYTES))
            rd_data = snap[reg_ptr[2:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            init_done  <= 1'b0;
            init_armed <= 1'b0;
            reg_ptr    <= 8'h00;
            bit_cnt    <= 4'd0;
            shreg      <= 8'h00;
            first_wr   <= 1'b0;
            mst_ack    <= 1'b0;
            for (int i = 0; i < NUM_DATA_BYTES; i++)
                snap[i] <= 8'h00;
        end else if (stop) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
        end else if (start) begin
            state   <= ADDR;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= 4'd0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shreg   <= {shreg[6:0], sda_s};
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt <= 4'd0;
                        if (shreg[7:1] == DEV_ADDR) begin
                            state  <= ADDR_ACK;
                            sda_oe <= 1'b1;
                            busy   <= 1'b1;
                            first_wr <= ~shreg[0];
                            // Snapshot now so the whole read sees one sample.
                            if (shreg[0]) begin
                                snap[0] <= stick_x;
                                snap[1] <= stick_y;
                                snap[2] <= accel_x[9:2];
                                snap[3] <= accel_y[9:2];
                                snap[4] <= accel_z[9:2];
                                snap[5] <= low_bits_byte(accel_x, accel_y, accel_z, c, z);
                            end
                        end else begin
                            state <= WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (first_wr) begin
                            state  <= WR_BYTE;
                            sda_oe <= 1'b0;
                        end else begin
                            state  <= RD_BYTE;
                            shreg  <= rd_data;
                            sda_oe <= ~rd_data[7];
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        shreg   <= {shreg[6:0], sda_s};
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt <= 4'd0;
                        state   <= WR_ACK;
                        sda_oe  <= 1'b1;
                        if (first_wr) begin
                            reg_ptr  <= shreg;
                            first_wr <= 1'b0;
                        end else begin
                            if (reg_ptr == INIT_REG1 && shreg == INIT_VAL1)
                                init_armed <= 1'b1;
                            if (init_armed && reg_ptr == INIT_REG2 && shreg == INIT_VAL2)
                                init_done <= 1'b1;
                            reg_ptr <= reg_ptr + 8'd1;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        state  <= WR_BYTE;
                        sda_oe <= 1'b0;
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            state   <= RD_ACK;
                            sda_oe  <= 1'b0;
                            reg_ptr <= reg_ptr + 8'd1;
                        end else begin
                            shreg  <= {shreg[6:0], 1'b0};
                            sda_oe <= ~shreg[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        mst_ack <= ~sda_s;
                    end else if (scl_fall) begin
                        if (mst_ack) begin
                            state  <= RD_BYTE;
                            shreg  <= rd_data;
                            sda_oe <= ~rd_data[7];
                        end else begin
                            state <= WAIT_STOP;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    sda_oe <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nunchuck_responder.sv
module tb_nunchuck_responder;
    import nunchuck_pkg::*;

    localparam int Q = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [7:0] stick_x = 8'h00, stick_y = 8'h00;
    logic [9:0] accel_x = 10'h0, accel_y = 10'h0, accel_z = 10'h0;
    logic       btn_z = 1'b0, btn_c = 1'b0;
    logic       init_done, busy;
    logic [7:0] reg_ptr;
    wire        sda;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    nunchuck_responder dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .stick_x   (stick_x),
        .stick_y   (stick_y),
        .accel_x   (accel_x),
        .accel_y   (accel_y),
        .accel_z   (accel_z),
        .z         (btn_z),
        .c         (btn_c),
        .init_done (init_done),
        .busy      (busy),
        .reg_ptr   (reg_ptr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic i2c_start();
        m_low = 1'b0; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b1; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b0; #Q;
    endtask

    // One SCL period: drive b (1 = release), sample mid-high.
    task automatic put_bit(input logic b, output logic s);
        m_low = ~b; #Q;
        scl = 1'b1; #Q;
        s = sda;    #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) put_bit(b[i], s);
        put_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic rd_byte(input logic ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            put_bit(1'b1, s);
            b[i] = s;
        end
        put_bit(~ack, s);
    endtask

    task automatic set_inputs(input logic [7:0] sx, input logic [7:0] sy, input logic [9:0] ax,
                              input logic [9:0] ay, input logic [9:0] az, input logic bz, input logic bc);
        stick_x = sx; stick_y = sy;
        accel_x = ax; accel_y = ay; accel_z = az;
        btn_z = bz; btn_c = bc;
    endtask

    typedef struct packed {
        logic [7:0]  sx;
        logic [7:0]  sy;
        logic [9:0]  ax;
        logic [9:0]  ay;
        logic [9:0]  az;
        logic        bz;
        logic        bc;
        logic [7:0]  ptr;
        logic [47:0] exp;
    } vec_t;

    vec_t tbl [4];

    initial begin
        logic       a0, a1, a2, a3;
        logic [7:0] b;
        logic [47:0] got;
        logic       s;

        tbl[0] = '{sx: 8'h80, sy: 8'h7F, ax: 10'h2AB, ay: 10'h155, az: 10'h0F2, bz: 1'b1, bc: 1'b0,
                   ptr: 8'h00, exp: 48'h80_7F_AA_55_3C_9E};
        tbl[1] = '{sx: 8'h12, sy: 8'h34, ax: 10'h000, ay: 10'h3FF, az: 10'h201, bz: 1'b0, bc: 1'b1,
                   ptr: 8'h04, exp: 48'h80_71_FF_FF_FF_FF};
        tbl[2] = '{sx: 8'hC3, sy: 8'h3C, ax: 10'h3FC, ay: 10'h004, az: 10'h000, bz: 1'b0, bc: 1'b0,
                   ptr: 8'hFE, exp: 48'hFF_FF_C3_3C_FF_01};
        tbl[3] = '{sx: 8'h00, sy: 8'h00, ax: 10'h001, ay: 10'h002, az: 10'h003, bz: 1'b1, bc: 1'b1,
                   ptr: 8'h02, exp: 48'h00_00_00_E4_FF_FF};

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset init_done", {47'd0, init_done}, 48'd0);
        check("reset busy", {47'd0, busy}, 48'd0);
        check("reset reg_ptr", {40'd0, reg_ptr}, 48'd0);
        check("reset sda", {47'd0, sda}, 48'd1);

        // Read before init: every byte reads 0xFF.
        set_inputs(8'h80, 8'h7F, 10'h2AB, 10'h155, 10'h0F2, 1'b1, 1'b0);
        i2c_start();
        wr_byte(8'hA4, a0);
        wr_byte(8'h00, a1);
        i2c_start();
        wr_byte(8'hA5, a2);
        got = '0;
        for (int i = 0; i < 6; i++) begin
            rd_byte(i != 5, b);
            got = {got[39:0], b};
        end
        i2c_stop();
        check("preinit acks", {45'd0, a0, a1, a2}, 48'd7);
        check("preinit read", got, 48'hFF_FF_FF_FF_FF_FF);

        // Init sequence in two transactions.
        i2c_start();
        wr_byte(8'hA4, a0);
        check("busy after addr ack", {47'd0, busy}, 48'd1);
        wr_byte(8'hF0, a1);
        wr_byte(8'h55, a2);
        i2c_stop();
        check("init1 acks", {45'd0, a0, a1, a2}, 48'd7);
        check("init_done after first write", {47'd0, init_done}, 48'd0);
        check("busy after stop", {47'd0, busy}, 48'd0);
        i2c_start();
        wr_byte(8'hA4, a0);
        wr_byte(8'hFB, a1);
        wr_byte(8'h00, a2);
        i2c_stop();
        check("init2 acks", {45'd0, a0, a1, a2}, 48'd7);
        check("init_done after second write", {47'd0, init_done}, 48'd1);
        check("reg_ptr after init", {40'd0, reg_ptr}, 48'hFC);

        // Table: set ptr, repeated START, 6-byte read.
        for (int v = 0; v < 4; v++) begin
            set_inputs(tbl[v].sx, tbl[v].sy, tbl[v].ax, tbl[v].ay, tbl[v].az, tbl[v].bz, tbl[v].bc);
            i2c_start();
            wr_byte(8'hA4, a0);
            wr_byte(tbl[v].ptr, a1);
            i2c_start();
            wr_byte(8'hA5, a2);
            check($sformatf("vec%0d busy", v), {47'd0, busy}, 48'd1);
            got = '0;
            for (int i = 0; i < 6; i++) begin
                rd_byte(i != 5, b);
                got = {got[39:0], b};
            end
            i2c_stop();
            check($sformatf("vec%0d acks", v), {45'd0, a0, a1, a2}, 48'd7);
            check($sformatf("vec%0d data", v), got, tbl[v].exp);
            check($sformatf("vec%0d reg_ptr", v), {40'd0, reg_ptr}, {40'd0, tbl[v].ptr + 8'd6});
            check($sformatf("vec%0d busy idle", v), {47'd0, busy}, 48'd0);
        end

        // Inputs change mid-read: later bytes still come from the snapshot.
        set_inputs(8'h80, 8'h7F, 10'h2AB, 10'h155, 10'h0F2, 1'b1, 1'b0);
        i2c_start();
        wr_byte(8'hA4, a0);
        wr_byte(8'h00, a1);
        i2c_start();
        wr_byte(8'hA5, a2);
        got = '0;
        for (int i = 0; i < 3; i++) begin
            rd_byte(1'b1, b);
            got = {got[39:0], b};
        end
        set_inputs(8'h01, 8'h02, 10'h000, 10'h3FF, 10'h3FF, 1'b0, 1'b1);
        for (int i = 3; i < 6; i++) begin
            rd_byte(i != 5, b);
            got = {got[39:0], b};
        end
        i2c_stop();
        check("snapshot coherence", got, 48'h80_7F_AA_55_3C_9E);

        // Wrong address: no ACK, not busy, following byte ignored.
        i2c_start();
        wr_byte(8'hA6, a0);
        check("bad addr busy", {47'd0, busy}, 48'd0);
        wr_byte(8'h10, a1);
        i2c_stop();
        check("bad addr no acks", {46'd0, a0, a1}, 48'd0);
        check("bad addr reg_ptr", {40'd0, reg_ptr}, 48'h06);

        // Reset during bit 3 of a read byte that is all zeros.
        set_inputs(8'h00, 8'h00, 10'h000, 10'h000, 10'h000, 1'b0, 1'b0);
        i2c_start();
        wr_byte(8'hA4, a0);
        wr_byte(8'h00, a1);
        i2c_start();
        wr_byte(8'hA5, a2);
        for (int i = 0; i < 4; i++) put_bit(1'b1, s);
        check("bit3 driven low", {47'd0, sda}, 48'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("sda released after rst", {47'd0, sda}, 48'd1);
        check("rst busy", {47'd0, busy}, 48'd0);
        check("rst init_done", {47'd0, init_done}, 48'd0);
        @(negedge clk);
        rst = 1'b0;
        #Q;
        i2c_start();
        wr_byte(8'hA4, a0);
        wr_byte(8'h00, a1);
        i2c_stop();
        check("post-rst write acks", {46'd0, a0, a1}, 48'd3);
        check("post-rst reg_ptr", {40'd0, reg_ptr}, 48'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
